rv32i_pipe_ctrl: RTL and testbench
==================================

Name: rv32i_pipe_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage RV32I pipeline (F/D/E/M/W).
- Generates per-stage stall (hold) and bubble (flush-to-NOP) controls from:
  - load-use hazards,
  - execute-stage control-flow redirects,
  - multi-cycle data-memory waits,
  - retired faults.
- Owns a halt state machine, a memory-wait timeout watchdog and saturating stall/flush event counters.
- Sits beside the pipeline registers. The pipeline gates its always_ff updates with the stall outputs and loads NOP fields on bubble.

Parameters:
- CNT_W, 16, width of stall_count and flush_count.
- MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before watchdog fault; legal range 1..2^16-1.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- d_rs1  in  5  rs1 index of instruction in D
- d_rs2  in  5  rs2 index of instruction in D
- d_use_rs1  in  1  D instruction reads rs1
- d_use_rs2  in  1  D instruction reads rs2
- e_rd  in  5  destination of instruction in E
- e_is_load  in  1  E holds a LOAD
- e_redirect  in  1  E resolved a taken branch/JAL/JALR
- m_mem_req  in  1  M stage is accessing data memory
- m_mem_ready  in  1  data memory completes access this cycle
- w_fault  in  1  fault retiring in W
- f_stall, d_stall, e_stall, m_stall  out  1 each  hold the respective pipeline register
- d_bubble, e_bubble, w_bubble  out  1 each  load NOP into the respective pipeline register
- pc_stall  out  1  hold program counter
- pc_redirect  out  1  PC loads target from E
- halted  out  1  core halted
- timeout_fault  out  1  sticky watchdog fault
- stall_count  out  CNT_W  cycles with pc_stall=1 while not halted
- flush_count  out  CNT_W  redirects taken

Behaviour:
- Reset is asynchronous, active-high. While reset=1 or after reset:
  - state=RUN; all stall/bubble/redirect outputs 0; halted=0, timeout_fault=0; counters 0; watchdog counter 0.
- FSM states: RUN, MEM_WAIT, HALT. Registered state. Outputs are combinational from state + inputs.
- Load-use hazard (LU) = e_is_load & e_rd!=0 & ((d_use_rs1 & d_rs1==e_rd) | (d_use_rs2 & d_rs2==e_rd)). x0 never hazards.
- MW = m_mem_req & !m_mem_ready.
- RUN priority: w_fault > MW > e_redirect > LU.
  - w_fault=1: next HALT; outputs this cycle as in HALT.
  - MW=1: pc/f/d/e/m_stall=1, w_bubble=1, pc_redirect=0. Next MEM_WAIT, watchdog=1.
  - e_redirect=1: pc_redirect=1, d_bubble=1, e_bubble=1, no stalls. flush_count+1.
  - LU=1: pc_stall=f_stall=d_stall=1, e_bubble=1. Latency: one bubble per load-use pair.
- MEM_WAIT:
  - Same stall/bubble outputs as MW while MW=1; watchdog increments.
  - m_mem_ready=1: no stalls that cycle; normal RUN evaluation of e_redirect/LU applies; next RUN. A redirect frozen in E is honoured here, not lost.
  - w_fault during MEM_WAIT: next HALT.
  - Watchdog reaches MEM_TIMEOUT with MW still 1: timeout_fault<=1, next HALT.
- HALT: all stall outputs=1, w_bubble=1, halted=1, pc_redirect=0. Stays until reset; counters frozen.
- Counters saturate at 2^CNT_W-1, no wrap. stall_count increments on any cycle with pc_stall=1 in RUN/MEM_WAIT.
- Simultaneous LU and e_redirect: redirect wins (D instruction is squashed), no stall.
- Reset mid-MEM_WAIT or mid-HALT returns to RUN immediately (async).

Test Plan:
- LOAD x5 in E (e_is_load=1,e_rd=5), D uses rs2=5 -> one cycle pc/f/d_stall=1, e_bubble=1, stall_count=1; e_rd=0 -> no stall.
- e_redirect=1 for one cycle -> pc_redirect=1, d_bubble=e_bubble=1, flush_count=1; with LU simultaneously -> no stall, flush_count=1, stall_count=0.
- m_mem_req=1, m_mem_ready=0 for 3 cycles then 1 -> 3 cycles all stalls + w_bubble, back to RUN on 4th, stall_count=3.
- MEM_TIMEOUT=4, mem never ready -> timeout_fault=1 and halted=1 after 4 MEM_WAIT cycles, stays until reset.
- w_fault=1 in RUN -> next cycle halted=1, all stalls=1; assert reset asynchronously mid-cycle -> outputs 0 immediately.
- MW with e_redirect held -> pc_redirect=0 during wait, pc_redirect=1 on ready cycle, flush_count=1.

Source files
------------

// File: rtl/rv32i_pipe_ctrl_if.sv
// Control bundle between the RV32I pipeline and its hazard/sequencing controller.
// The pipeline side drives hazard sources; the controller drives stall/bubble/redirect.
interface rv32i_pipe_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       d_rs1;
  logic [4:0]       d_rs2;
  logic             d_use_rs1;
  logic             d_use_rs2;
  logic [4:0]       e_rd;
  logic             e_is_load;
  logic             e_redirect;
  logic             m_mem_req;
  logic             m_mem_ready;
  logic             w_fault;
  logic             f_stall;
  logic             d_stall;
  logic             e_stall;
  logic             m_stall;
  logic             d_bubble;
  logic             e_bubble;
  logic             w_bubble;
  logic             pc_stall;
  logic             pc_redirect;
  logic             halted;
  logic             timeout_fault;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output d_rs1, d_rs2, d_use_rs1, d_use_rs2, e_rd, e_is_load, e_redirect,
           m_mem_req, m_mem_ready, w_fault,
    input  f_stall, d_stall, e_stall, m_stall, d_bubble, e_bubble, w_bubble,
           pc_stall, pc_redirect, halted, timeout_fault, stall_count, flush_count
  );

  modport slave (
    input  d_rs1, d_rs2, d_use_rs1, d_use_rs2, e_rd, e_is_load, e_redirect,
           m_mem_req, m_mem_ready, w_fault,
    output f_stall, d_stall, e_stall, m_stall, d_bubble, e_bubble, w_bubble,
           pc_stall, pc_redirect, halted, timeout_fault, stall_count, flush_count
  );
endinterface

// File: rtl/rv32i_pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline: stall/bubble
// generation, halt FSM, data-memory wait watchdog and saturating event counters.
module rv32i_pipe_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                clock,
  input  logic                reset,
  rv32i_pipe_ctrl_if.slave    ctl
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_e;

  localparam logic [15:0]      TIMEOUT = 16'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q;
  logic [15:0]      wdog_q;
  logic             tfault_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lu, mw, active, in_halt, fault_now, hold_all, redirect, lu_stall;
  logic front_stall, halt_w;

  // Outputs are forced quiet while reset is held, independent of the inputs.
  always_comb begin
    lu = ctl.e_is_load && (ctl.e_rd != 5'd0) &&
         ((ctl.d_use_rs1 && (ctl.d_rs1 == ctl.e_rd)) ||
          (ctl.d_use_rs2 && (ctl.d_rs2 == ctl.e_rd)));
    mw          = ctl.m_mem_req && !ctl.m_mem_ready;
    in_halt     = !reset && (state_q == HALT);
    active      = !reset && (state_q != HALT);
    fault_now   = active && ctl.w_fault;
    hold_all    = in_halt || fault_now || (active && mw);
    redirect    = active && !ctl.w_fault && !mw && ctl.e_redirect;
    lu_stall    = active && !ctl.w_fault && !mw && !ctl.e_redirect && lu;
    front_stall = hold_all || lu_stall;
    halt_w      = in_halt || fault_now;

    stall_cnt_d = stall_cnt_q;
    if (front_stall && !halt_w && (stall_cnt_q != CNT_MAX))
      stall_cnt_d = stall_cnt_q + 1'b1;
    flush_cnt_d = flush_cnt_q;
    if (redirect && (flush_cnt_q != CNT_MAX))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  assign ctl.pc_stall      = front_stall;
  assign ctl.f_stall       = front_stall;
  assign ctl.d_stall       = front_stall;
  assign ctl.e_stall       = hold_all;
  assign ctl.m_stall       = hold_all;
  assign ctl.w_bubble      = hold_all;
  assign ctl.d_bubble      = redirect;
  assign ctl.e_bubble      = redirect || lu_stall;
  assign ctl.pc_redirect   = redirect;
  assign ctl.halted        = halt_w;
  assign ctl.timeout_fault = tfault_q;
  assign ctl.stall_count   = stall_cnt_q;
  assign ctl.flush_count   = flush_cnt_q;

  // HALT is terminal until reset; the watchdog only runs across consecutive wait cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      wdog_q      <= '0;
      tfault_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      if (state_q != HALT) begin
        if (ctl.w_fault) begin
          state_q <= HALT;
          wdog_q  <= '0;
        end else if (mw) begin
          if (state_q == RUN) begin
            state_q <= MEM_WAIT;
            wdog_q  <= 16'd1;
          end else if (wdog_q >= TIMEOUT) begin
            tfault_q <= 1'b1;
            state_q  <= HALT;
          end else begin
            wdog_q <= wdog_q + 16'd1;
          end
        end else begin
          state_q <= RUN;
          wdog_q  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rv32i_pipe_ctrl.sv
// Self-checking bench for rv32i_pipe_ctrl: directed vector table, hand sequences
// for timeout/reset/saturation, and randomized traffic against a reference model.
module tb_rv32i_pipe_ctrl;
  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 4;
  localparam int CMAX        = (1 << CNT_W) - 1;

  // {pc_stall,f_stall,d_stall,e_stall,m_stall,d_bubble,e_bubble,w_bubble,pc_redirect,halted,timeout_fault}
  localparam logic [10:0] P_NONE = 11'b00000000000;
  localparam logic [10:0] P_LU   = 11'b11100010000;
  localparam logic [10:0] P_RED  = 11'b00000110100;
  localparam logic [10:0] P_MW   = 11'b11111001000;
  localparam logic [10:0] P_HLT  = 11'b11111001010;
  localparam logic [10:0] P_HTF  = 11'b11111001011;

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, ld, red, req, rdy, flt;
    logic [10:0] exp;
    int          sc, fc;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  bit m_halt, m_tf;
  int m_wait, m_sc, m_fc;

  rv32i_pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();
  rv32i_pipe_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clock(clock), .reset(reset), .ctl(bus)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish before 2ms");
    $fatal(1, "bench timeout");
  end

  function automatic vec_t mk(input logic [4:0] rs1, rs2, rd,
                              input logic u1, u2, ld, red, req, rdy, flt,
                              input logic [10:0] exp, input int sc, fc);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.u1 = u1; v.u2 = u2; v.ld = ld;
    v.red = red; v.req = req; v.rdy = rdy; v.flt = flt;
    v.exp = exp; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  function automatic logic [10:0] outs();
    return {bus.pc_stall, bus.f_stall, bus.d_stall, bus.e_stall, bus.m_stall,
            bus.d_bubble, bus.e_bubble, bus.w_bubble, bus.pc_redirect,
            bus.halted, bus.timeout_fault};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: priority rules applied directly; timeout means more than
  // MEM_TIMEOUT wait cycles after the one that opened the wait.
  function automatic logic [10:0] model_out(input vec_t v);
    bit mw, lu;
    mw = v.req && !v.rdy;
    lu = v.ld && (v.rd != 0) && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
    if (m_halt)     return m_tf ? P_HTF : P_HLT;
    if (v.flt)      return P_HLT | {10'b0, m_tf};
    if (mw)         return P_MW;
    if (v.red)      return P_RED;
    if (lu)         return P_LU;
    return P_NONE;
  endfunction

  task automatic model_step(input vec_t v);
    logic [10:0] o;
    o = model_out(v);
    if (o[10] && !o[1]) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
    if (o[2])           m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
    if (!m_halt) begin
      if (v.flt) m_halt = 1'b1;
      else if (v.req && !v.rdy) begin
        m_wait++;
        if (m_wait > MEM_TIMEOUT) begin m_tf = 1'b1; m_halt = 1'b1; end
      end else m_wait = 0;
    end
  endtask

  task automatic model_clear();
    m_halt = 0; m_tf = 0; m_wait = 0; m_sc = 0; m_fc = 0;
  endtask

  task automatic drive(input vec_t v);
    bus.d_rs1 = v.rs1; bus.d_rs2 = v.rs2; bus.e_rd = v.rd;
    bus.d_use_rs1 = v.u1; bus.d_use_rs2 = v.u2; bus.e_is_load = v.ld;
    bus.e_redirect = v.red; bus.m_mem_req = v.req; bus.m_mem_ready = v.rdy;
    bus.w_fault = v.flt;
  endtask

  task automatic run_vec(input vec_t v, input string name, input bit use_table);
    @(negedge clock);
    drive(v);
    #1;
    if (use_table) begin
      check({name, " outs"}, 32'(outs()), 32'(v.exp));
      check({name, " stall_count"}, 32'(bus.stall_count), v.sc);
      check({name, " flush_count"}, 32'(bus.flush_count), v.fc);
    end else begin
      check({name, " outs"}, 32'(outs()), 32'(model_out(v)));
      check({name, " stall_count"}, 32'(bus.stall_count), m_sc);
      check({name, " flush_count"}, 32'(bus.flush_count), m_fc);
    end
    model_step(v);
  endtask

  // Reset is raised mid-cycle with a fault still presented; outputs must clear at once.
  task automatic do_reset(input string name);
    @(negedge clock);
    drive(mk(5'd1, 5'd1, 5'd1, 1, 1, 1, 1, 1, 0, 1, P_NONE, 0, 0));
    #2 reset = 1'b1;
    #1;
    check({name, " reset outs"}, 32'(outs()), 32'(P_NONE));
    check({name, " reset stall_count"}, 32'(bus.stall_count), 0);
    check({name, " reset flush_count"}, 32'(bus.flush_count), 0);
    @(negedge clock);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, P_NONE, 0, 0));
    reset = 1'b0;
    model_clear();
  endtask

  vec_t tbl[19];
  vec_t v;

  initial begin
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, P_NONE, 0, 0);
    tbl[1]  = mk(0, 5, 5, 0, 1, 1, 0, 0, 0, 0, P_LU,   0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, P_NONE, 1, 0);
    tbl[3]  = mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, P_NONE, 1, 0);
    tbl[4]  = mk(7, 0, 7, 0, 0, 1, 0, 0, 0, 0, P_NONE, 1, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, P_RED,  1, 0);
    tbl[6]  = mk(5, 0, 5, 1, 0, 1, 1, 0, 0, 0, P_RED,  1, 1);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, P_NONE, 1, 2);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, P_MW,   1, 2);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, P_MW,   2, 2);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, P_MW,   3, 2);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, P_NONE, 4, 2);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, P_NONE, 4, 2);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, P_MW,   4, 2);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, P_MW,   5, 2);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, P_RED,  6, 2);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, P_NONE, 6, 3);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, P_HLT,  6, 3);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, P_HLT,  6, 3);

    model_clear();
    drive(tbl[0]);
    #3;
    check("initial reset outs", 32'(outs()), 32'(P_NONE));
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 19; i++) run_vec(tbl[i], $sformatf("tbl[%0d]", i), 1'b1);
    do_reset("after_halt");

    // Memory never becomes ready: watchdog fires and halt is sticky.
    for (int i = 0; i < 5; i++)
      run_vec(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, P_MW, i, 0), $sformatf("wd[%0d]", i), 1'b1);
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, P_HTF, 5, 0), "wd_halt", 1'b1);
    run_vec(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, P_HTF, 5, 0), "wd_sticky", 1'b1);
    do_reset("after_timeout");

    // Counter saturation.
    for (int i = 0; i < 18; i++)
      run_vec(mk(3, 0, 3, 1, 0, 1, 0, 0, 0, 0, P_LU, 0, 0), "sat_lu", 1'b0);
    for (int i = 0; i < 18; i++)
      run_vec(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, P_RED, 0, 0), "sat_red", 1'b0);
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, P_NONE, CMAX, CMAX), "sat_final", 1'b1);
    do_reset("after_sat");

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 99) < 3) do_reset("rand");
      v.rs1 = 5'($urandom_range(0, 3)); v.rs2 = 5'($urandom_range(0, 3));
      v.rd  = 5'($urandom_range(0, 3));
      v.u1 = 1'($urandom); v.u2 = 1'($urandom); v.ld = 1'($urandom);
      v.red = ($urandom_range(0, 99) < 20); v.req = ($urandom_range(0, 99) < 35);
      v.rdy = 1'($urandom); v.flt = ($urandom_range(0, 99) < 2);
      v.exp = P_NONE; v.sc = 0; v.fc = 0;
      run_vec(v, "rand", 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
